// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes,
// FSM state encoding and the funct3 legality rule.
package dmem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        DMR_IDLE,
        DMR_WAIT,
        DMR_RESP
    } dmr_state_t;

    // Stores have no unsigned variants, so 100/101 are only legal for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between a data-access requester and the responder.
// The requester drives master; the memory side uses slave.
interface dmem_responder_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_lsu_align.sv
// Lane steering for byte/half/word accesses: store enables and replication, load extension, fault flags.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module dmem_responder_lsu_align
    import dmem_responder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be,
    output logic [XLEN-1:0] sdata,
    output logic [XLEN-1:0] ldata,
    output logic            misalign,
    output logic            illegal
);
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign sel_b = rword[{lane, 3'b000} +: 8];
    assign sel_h = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be    = 4'b0000;
        sdata = wdata;
        ldata = '0;
        case (funct3)
            F3_LB: begin
                be    = 4'b0001 << lane;
                sdata = {4{wdata[7:0]}};
                ldata = {{(XLEN-8){sel_b[7]}}, sel_b};
            end
            F3_LH: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                sdata = {2{wdata[15:0]}};
                ldata = {{(XLEN-16){sel_h[15]}}, sel_h};
            end
            F3_LW: begin
                be    = 4'b1111;
                ldata = rword;
            end
            F3_LBU: ldata = {{(XLEN-8){1'b0}}, sel_b};
            F3_LHU: ldata = {{(XLEN-16){1'b0}}, sel_h};
            default: ;
        endcase
    end

    assign misalign = ((funct3[1:0] == 2'b01) && lane[0]) || ((funct3 == F3_LW) && (lane != 2'b00));
    assign illegal  = f3_illegal(funct3, we);

endmodule

// File: rtl/dmem_responder.sv
// RV32I data-memory responder with a modelled access latency.
// Latency: rsp_valid rises LATENCY edges after request accept.
// Backpressure: one request in flight; req_ready low until the response is taken.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmr_state_t      state;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic [AW-1:0]   widx;
    logic [XLEN-1:0] rword;
    logic [3:0]      be;
    logic [XLEN-1:0] sdata;
    logic [XLEN-1:0] ldata;
    logic            misalign;
    logic            illegal;
    logic            oor;
    logic            err;
    logic            access;

    assign widx   = addr_q[AW+1:2];
    assign rword  = mem[widx];
    assign oor    = addr_q[XLEN-1:2] >= (XLEN-2)'(DEPTH);
    assign err    = misalign | illegal | oor;
    assign access = (state == DMR_WAIT) && (cnt == '0);

    dmem_responder_lsu_align #(.XLEN(XLEN)) u_align (
        .we       (we_q),
        .funct3   (funct3_q),
        .lane     (addr_q[1:0]),
        .wdata    (wdata_q),
        .rword    (rword),
        .be       (be),
        .sdata    (sdata),
        .ldata    (ldata),
        .misalign (misalign),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DMR_IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                DMR_IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        cnt      <= CW'(LATENCY - 1);
                        state    <= DMR_WAIT;
                    end
                end
                DMR_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_err_q   <= err;
                        rsp_rdata_q <= (we_q || err) ? '0 : ldata;
                        rsp_valid_q <= 1'b1;
                        state       <= DMR_RESP;
                    end
                end
                DMR_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= DMR_IDLE;
                    end
                end
                default: state <= DMR_IDLE;
            endcase
        end
    end

    // Array is deliberately not reset; a reset on the access edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && access && we_q && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= sdata[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state == DMR_IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
